vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Arbitrates one single-port synchronous frame-buffer RAM (RGB444 pixels) between two requesters.
//  The requesters are the VGA scan-out fetch (read port D) and the button-driven draw engine (write port W).
//  It sits between the pixel-fetch logic of test_VGA and the video RAM, and issues one RAM command per clock.
//  The display has priority during active video; the writer has priority during blanking.
// PARAMETERS
//  AW          15  frame-buffer address width (words)
//  DW          12  pixel width, {R[3:0],G[3:0],B[3:0]}
//  STARVE_MAX  64  consecutive denied writer cycles before starve_err sets (FB_ARB_STARVE_EN only)
// PORTS
//  clk        in   1   system clock, single domain
//  rst        in   1   synchronous reset, active-low (asserted when 0, sampled on posedge clk)
//  blank      in   1   1 = horizontal or vertical blanking, 0 = active video
//  d_req      in   1   display read request
//  d_addr     in   AW  display read address
//  d_gnt      out  1   display request accepted this cycle (combinational)
//  d_rvalid   out  1   d_rdata valid
//  d_rdata    out  DW  read pixel
//  w_req      in   1   writer request; w_addr/w_data held stable until w_gnt
//  w_addr     in   AW  write address
//  w_data     in   DW  write pixel
//  w_gnt      out  1   write accepted this cycle (combinational)
//  mem_addr   out  AW  RAM address (registered)
//  mem_we     out  1   RAM write enable (registered)
//  mem_en     out  1   RAM enable (registered)
//  mem_wdata  out  DW  RAM write data (registered)
//  mem_rdata  in   DW  RAM read data, valid 1 cycle after a read command
//  starve_err out  1   sticky writer-starvation flag
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all outputs 0, cmd state S_IDLE, rvalid pipe cleared, starve counter 0.
//  - Arbitration, cycle N, combinational:
//      - blank=0: d_gnt=d_req; w_gnt=w_req & ~d_req.
//      - blank=1: w_gnt=w_req; d_gnt=d_req & ~w_req.
//      - At most one grant per cycle. No grants while rst=0.
//  - Command stage, posedge ending N: state <= S_RD (d_gnt) / S_WR (w_gnt) / S_IDLE.
//      - mem_en=1 and mem_addr set from the granted port.
//      - mem_we=1, mem_wdata=w_data only in S_WR.
//      - In S_IDLE: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
//  - Read return: RAM samples at the edge ending N+1; mem_rdata is valid in N+2.
//      - d_rvalid is registered from (state==S_RD) and asserts in N+2.
//      - d_rdata = mem_rdata when d_rvalid=1, else 0.
//      - Latency d_gnt -> d_rvalid = 2 clk. Back-to-back grants give 1 pixel/clk.
//  - Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first).
//      - The arbiter adds no bypass.
//  - Writer waits while blank=0 and d_req=1. No preemption of the display in active video, ever.
//  - A blank transition takes effect in the same cycle; no grant is ever issued to both ports.
//  - Reset mid-operation: an in-flight read is dropped (no d_rvalid after rst=0).
//      - starve_err is cleared only by reset.
// CONFIGURATION
//  FB_ARB_STARVE_EN defined:
//  - 8-bit counter increments each cycle with w_req=1 & w_gnt=0.
//  - The counter clears on w_gnt or w_req=0 and saturates at STARVE_MAX.
//  - Reaching STARVE_MAX sets starve_err=1 (sticky).
//  FB_ARB_STARVE_EN undefined: no counter; starve_err tied to 0. Arbitration is identical.
// TESTING
//  1. rst=0 for 4 clk with d_req=w_req=1 -> no gnt, mem_en=0, d_rvalid=0, starve_err=0.
//  2. blank=0, d_req=1 at addr 0x0010..0x0013 for 4 clk -> d_gnt 4 clk.
//     -> d_rvalid 4 clk starting 2 clk later, in address order.
//  3. blank=0, d_req=w_req=1 (w_addr=0x0100, w_data=0xF00) -> d_gnt=1, w_gnt=0.
//     -> then blank=1 -> w_gnt=1 that cycle; mem_we=1, mem_addr=0x0100, mem_wdata=0xF00 next clk.
//  4. Write 0x0F0 to 0x0200 in blanking, read 0x0200 next cycle -> d_rdata=0x0F0 with d_rvalid.
//  5. FB_ARB_STARVE_EN, blank=0, d_req=1, w_req=1 held 64 clk -> starve_err=1.
//     -> stays 1 after w_gnt; clears only on rst=0.
//  6. Read granted, rst=0 asserted the next clk -> d_rvalid stays 0; after release, all outputs 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads win in active video, draw writes win in blanking.
// Optional writer-starvation monitor enabled with `define FB_ARB_STARVE_EN.
module vga_fb_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 12,
    parameter int STARVE_MAX = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blank,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          w_gnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          starve_err
);

    // Handshake: a requester holds req (and address/data) until it sees gnt
    // high in the same cycle; the command is issued on the following edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t state;
    state_t state_d;
    logic   rvalid_q;

    always_comb begin
        d_gnt   = 1'b0;
        w_gnt   = 1'b0;
        state_d = S_IDLE;
        if (rst) begin
            if (blank) begin
                w_gnt = w_req;
                d_gnt = d_req & ~w_req;
            end else begin
                d_gnt = d_req;
                w_gnt = w_req & ~d_req;
            end
        end
        if (d_gnt) begin
            state_d = S_RD;
        end else if (w_gnt) begin
            state_d = S_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state    <= state_d;
            rvalid_q <= (state == S_RD);
            if (d_gnt) begin
                mem_addr <= d_addr;
            end else if (w_gnt) begin
                mem_addr  <= w_addr;
                mem_wdata <= w_data;
            end
        end
    end

    // Enables decode straight from the registered command state.
    assign mem_en   = (state != S_IDLE);
    assign mem_we   = (state == S_WR);
    assign d_rvalid = rvalid_q;
    assign d_rdata  = rvalid_q ? mem_rdata : '0;

`ifdef FB_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt;
    logic [7:0] starve_cnt_d;
    logic       err_q;

    always_comb begin
        starve_cnt_d = '0;
        if (w_req && !w_gnt) begin
            starve_cnt_d = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_d;
            if (starve_cnt_d == STARVE_LIM) begin
                err_q <= 1'b1;
            end
        end
    end

    assign starve_err = err_q;
`else
    assign starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural write-first RAM, grant model and read-data scoreboard.
// Starvation expectations follow `define FB_ARB_STARVE_EN.
module tb_vga_fb_arbiter;

    localparam int AW = 15;
    localparam int DW = 12;
    localparam int NWORDS = 1 << AW;
`ifdef FB_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          blank;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          starve_err;

    vga_fb_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(64)) dut (
        .clk(clk), .rst(rst), .blank(blank),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_en(mem_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .starve_err(starve_err)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural single-port write-first RAM
    logic [DW-1:0] ram    [0:NWORDS-1];
    logic [DW-1:0] shadow [0:NWORDS-1];
    logic [DW-1:0] ram_q;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                ram_q         <= mem_wdata;
            end else begin
                ram_q <= ram[mem_addr];
            end
        end
    end
    assign mem_rdata = ram_q;

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    logic [1:0]    sched;
    logic          prev_any;
    logic          prev_w;
    int            exp_cnt;
    logic          exp_err;
    logic          last_wg;
    int            n_vec;
    int            n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs, check outputs at the falling edge
    task automatic step(input logic r, input logic b, input logic dr, input logic [AW-1:0] da,
                        input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic eg_d;
        logic eg_w;
        rst = r; blank = b; d_req = dr; d_addr = da;
        w_req = wr; w_addr = wa; w_data = wd;
        @(negedge clk);
        eg_w = r & wr & (b | ~dr);
        eg_d = r & dr & ~eg_w;
        check("d_gnt", 32'(d_gnt), 32'(eg_d));
        check("w_gnt", 32'(w_gnt), 32'(eg_w));
        check("mem_en", 32'(mem_en), 32'(prev_any));
        check("mem_we", 32'(mem_we), 32'(prev_w));
        check("d_rvalid", 32'(d_rvalid), 32'(sched[1]));
        if (sched[1]) begin
            check("d_rdata", 32'(d_rdata), 32'(exp_q.pop_front()));
        end else begin
            check("d_rdata_idle", 32'(d_rdata), 32'(0));
        end
        check("starve_err", 32'(starve_err), 32'(exp_err & STARVE_ON));

        if (eg_w) shadow[wa] = wd;
        if (eg_d) exp_q.push_back(shadow[da]);
        sched = {sched[0], eg_d};
        if (!r) begin
            if (sched[1]) void'(exp_q.pop_back());
            sched = 2'b00;
        end
        prev_any = eg_d | eg_w;
        prev_w   = eg_w;
        last_wg  = eg_w;

        if (!r) begin
            exp_cnt = 0;
            exp_err = 1'b0;
        end else if (wr && !eg_w) begin
            if (exp_cnt < 64) exp_cnt++;
            if (exp_cnt == 64) exp_err = 1'b1;
        end else begin
            exp_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          wpend;
        n_vec = 0; n_err = 0;
        sched = 2'b00; prev_any = 1'b0; prev_w = 1'b0;
        exp_cnt = 0; exp_err = 1'b0; last_wg = 1'b0;
        ram_q = '0;
        for (int i = 0; i < NWORDS; i++) begin
            ram[i]    = DW'(i * 37 + 5);
            shadow[i] = DW'(i * 37 + 5);
        end
        rst = 1'b0; blank = 1'b0; d_req = 1'b1; d_addr = '0;
        w_req = 1'b1; w_addr = '0; w_data = '0;
        @(posedge clk);
        #1;

        // reset held with both requests active
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 15'h0010, 1'b1, 15'h0100, 12'hABC);
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));

        // burst of four display reads in active video
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, AW'(16 + i), 1'b0, '0, '0);
        idle(3);

        // writer blocked in active video, wins as soon as blanking starts
        step(1'b1, 1'b0, 1'b1, 15'h0020, 1'b1, 15'h0100, 12'hF00);
        step(1'b1, 1'b1, 1'b1, 15'h0020, 1'b1, 15'h0100, 12'hF00);
        check("wr_mem_we", 32'(mem_we), 32'(1));
        check("wr_mem_addr", 32'(mem_addr), 32'(15'h0100));
        check("wr_mem_wdata", 32'(mem_wdata), 32'(12'hF00));
        idle(3);

        // write then immediate read of the same word
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 15'h0200, 12'h0F0);
        step(1'b1, 1'b1, 1'b1, 15'h0200, 1'b0, '0, '0);
        idle(3);
        check("raw_shadow", 32'(shadow[15'h0200]), 32'(12'h0F0));

        // random traffic on a small address window
        wpend = 1'b0; wa = '0; wd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!wpend && $urandom_range(0, 1) == 1) begin
                wpend = 1'b1;
                wa = AW'($urandom_range(0, 31));
                wd = DW'($urandom_range(0, 4095));
            end
            step(1'b1, 1'(($urandom_range(0, 3) == 0)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 31)), wpend, wa, wd);
            if (last_wg) wpend = 1'b0;
        end
        idle(3);

        // writer starvation under continuous display traffic
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b1, AW'(i), 1'b1, 15'h0300, 12'h123);
        check("starve_set", 32'(starve_err), 32'(STARVE_ON));
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 15'h0300, 12'h123);
        idle(3);
        check("starve_sticky", 32'(starve_err), 32'(STARVE_ON));

        // reset immediately after a read grant drops the read
        step(1'b1, 1'b0, 1'b1, 15'h0030, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
        check("mid_rst_mem_wdata", 32'(mem_wdata), 32'(0));
        idle(4);
        check("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
